// File: rtl/ex_cdb_result_queue_pkg.sv
// Shared execute-stage definitions: ALU encodings, zero-register tag and the CDB entry record.
package ex_cdb_result_queue_pkg;

  // Default destination tag width and the architectural zero register.
  localparam int unsigned CdbTagW = 6;
  localparam int unsigned ZeroTag = 31;

  // ALU function select.
  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluAnd  = 4'd2,
    AluOr   = 4'd3,
    AluXor  = 4'd4,
    AluSll  = 4'd5,
    AluSrl  = 4'd6,
    AluSra  = 4'd7,
    AluSlt  = 4'd8,
    AluSltu = 4'd9
  } alu_func_e;

  // ALU operand-B source select.
  typedef enum logic [1:0] {
    OpSelReg  = 2'd0,
    OpSelImm  = 2'd1,
    OpSelPc   = 2'd2,
    OpSelZero = 2'd3
  } op_sel_e;

  // One completed result as carried on the CDB (default tag width).
  typedef struct packed {
    logic [63:0]        result;
    logic [CdbTagW-1:0] tag;
    logic               is_branch;
    logic               take_branch;
  } cdb_entry_t;

  // Packed width of an entry for an arbitrary tag width.
  function automatic int unsigned cdb_entry_bits(input int unsigned tag_w);
    return 64 + tag_w + 2;
  endfunction

endpackage

// File: rtl/ex_cdb_result_queue_if.sv
// Execute-result input handshake and CDB output bus of the result queue.
interface ex_cdb_result_queue_if
  import ex_cdb_result_queue_pkg::*;
#(
  parameter int unsigned TAG_W = CdbTagW
);

  logic             X_valid;
  logic             X_ready;
  logic [63:0]      X_result;
  logic [TAG_W-1:0] X_tag;
  logic             X_is_branch;
  logic             X_take_branch;

  logic             cdb_grant;
  logic             cdb_valid;
  logic [63:0]      cdb_result;
  logic [TAG_W-1:0] cdb_tag;
  logic             cdb_is_branch;
  logic             cdb_take_branch;

  // Execute stage and CDB arbiter side.
  modport master (
    output X_valid, X_result, X_tag, X_is_branch, X_take_branch, cdb_grant,
    input  X_ready, cdb_valid, cdb_result, cdb_tag, cdb_is_branch, cdb_take_branch
  );

  // Queue side.
  modport slave (
    input  X_valid, X_result, X_tag, X_is_branch, X_take_branch, cdb_grant,
    output X_ready, cdb_valid, cdb_result, cdb_tag, cdb_is_branch, cdb_take_branch
  );

endinterface

// File: rtl/ex_cdb_fifo_mem.sv
// Result-queue storage: DEPTH x WIDTH register array, one write port, one async read port.
module ex_cdb_fifo_mem #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 72
) (
  input  logic                     clock,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is never reset; validity is tracked by the queue's count.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ex_cdb_result_queue.sv
// In-order result queue between execute and the common data bus, with flush and zero-reg filter.
module ex_cdb_result_queue
  import ex_cdb_result_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned TAG_W    = CdbTagW,
  parameter int unsigned ZERO_TAG = ZeroTag
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  ex_cdb_result_queue_if.slave   bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [63:0]      result;
    logic [TAG_W-1:0] tag;
    logic             is_branch;
    logic             take_branch;
  } entry_t;

  localparam int unsigned EntryW = cdb_entry_bits(TAG_W);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ex_cdb_result_queue: DEPTH must be a power of two and at least 2");
  end

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  logic   full;
  logic   empty;
  logic   accept;
  logic   zero_write;
  logic   enq;
  logic   pop;
  entry_t wr_entry;
  entry_t rd_entry;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);

  // Ready depends only on registered occupancy.
  assign bus.X_ready = ~full;

  assign accept     = bus.X_valid & ~full;
  // Non-branch writes to the zero register are consumed but carry nothing worth retiring.
  assign zero_write = (bus.X_tag == TAG_W'(ZERO_TAG)) & ~bus.X_is_branch;
  assign enq        = accept & ~zero_write & ~flush;
  assign pop        = ~empty & bus.cdb_grant & ~flush;

  assign wr_entry = '{
    result:      bus.X_result,
    tag:         bus.X_tag,
    is_branch:   bus.X_is_branch,
    take_branch: bus.X_take_branch
  };

  ex_cdb_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EntryW)
  ) u_mem (
    .clock   (clock),
    .wr_en   (enq),
    .wr_addr (tail_q),
    .wr_data (wr_entry),
    .rd_addr (head_q),
    .rd_data (rd_entry)
  );

  // Next-state for pointers and occupancy; flush wins over any push or pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) begin
        tail_d = tail_q + PtrW'(1);
      end
      if (pop) begin
        head_d = head_q + PtrW'(1);
      end
      case ({enq, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Queue state registers, cleared asynchronously by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

  // Head entry onto the CDB; data is zeroed while the queue is empty.
  always_comb begin
    bus.cdb_valid       = ~empty;
    bus.cdb_result      = '0;
    bus.cdb_tag         = '0;
    bus.cdb_is_branch   = 1'b0;
    bus.cdb_take_branch = 1'b0;
    if (!empty) begin
      bus.cdb_result      = rd_entry.result;
      bus.cdb_tag         = rd_entry.tag;
      bus.cdb_is_branch   = rd_entry.is_branch;
      bus.cdb_take_branch = rd_entry.take_branch;
    end
  end

endmodule

// File: tb/tb_ex_cdb_result_queue.sv
// Directed table-driven bench for ex_cdb_result_queue.
module tb_ex_cdb_result_queue;

  localparam int unsigned Depth = 4;
  localparam int unsigned TagW  = 6;

  logic       clock;
  logic       reset;
  logic       flush;
  logic [2:0] count;

  ex_cdb_result_queue_if #(.TAG_W(TagW)) bus ();

  ex_cdb_result_queue #(
    .DEPTH    (Depth),
    .TAG_W    (TagW),
    .ZERO_TAG (31)
  ) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .count (count),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic        xv;
    logic [63:0] res;
    logic [5:0]  tag;
    logic        br;
    logic        tk;
    logic        fl;
    logic        gr;
    int unsigned e_cnt;
    logic        e_valid;
    logic [5:0]  e_tag;
    logic [63:0] e_res;
    logic        e_br;
    logic        e_tk;
    logic        e_ready;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic xv, input logic [63:0] res, input logic [5:0] tag,
                     input logic br, input logic tk, input logic fl, input logic gr,
                     input int unsigned e_cnt, input logic e_valid, input logic [5:0] e_tag,
                     input logic [63:0] e_res, input logic e_br, input logic e_tk,
                     input logic e_ready);
    vec_t v;
    v.xv = xv; v.res = res; v.tag = tag; v.br = br; v.tk = tk; v.fl = fl; v.gr = gr;
    v.e_cnt = e_cnt; v.e_valid = e_valid; v.e_tag = e_tag; v.e_res = e_res;
    v.e_br = e_br; v.e_tk = e_tk; v.e_ready = e_ready;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic xv, input logic [63:0] res, input logic [5:0] tag,
                       input logic br, input logic tk, input logic fl, input logic gr);
    bus.X_valid       = xv;
    bus.X_result      = res;
    bus.X_tag         = tag;
    bus.X_is_branch   = br;
    bus.X_take_branch = tk;
    flush             = fl;
    bus.cdb_grant     = gr;
  endtask

  // Invariants checked mid-cycle while out of reset.
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      logic [1:0] diff;
      diff = dut.tail_q - dut.head_q;
      if (count == 3'(Depth)) begin
        chk("inv_full_not_ready", 0, 64'(bus.X_ready), 64'd0);
        chk("inv_full_ptrs_equal", 0, 64'(dut.tail_q), 64'(dut.head_q));
      end else begin
        chk("inv_count_vs_ptrs", 0, 64'(count), 64'(diff));
      end
      if (bus.cdb_valid === 1'b0) begin
        chk("inv_idle_data_zero", 0,
            {bus.cdb_result[63:8], bus.cdb_result[7:0] | {bus.cdb_tag, bus.cdb_is_branch,
             bus.cdb_take_branch}}, 64'd0);
      end
    end
  end

  initial begin
    // Expected state after each edge: cnt, valid, head tag, head result, br, tk, ready.
    add(1, 64'h1234, 5, 0, 0, 0, 1,  1, 1, 5, 64'h1234, 0, 0, 1);
    add(0, 64'h0,    0, 0, 0, 0, 1,  0, 0, 0, 64'h0,    0, 0, 1);
    add(1, 64'h101,  1, 0, 0, 0, 0,  1, 1, 1, 64'h101,  0, 0, 1);
    add(1, 64'h102,  2, 0, 0, 0, 0,  2, 1, 1, 64'h101,  0, 0, 1);
    add(1, 64'h103,  3, 0, 0, 0, 0,  3, 1, 1, 64'h101,  0, 0, 1);
    add(1, 64'h104,  4, 0, 0, 0, 0,  4, 1, 1, 64'h101,  0, 0, 0);
    add(1, 64'h106,  6, 0, 0, 0, 0,  4, 1, 1, 64'h101,  0, 0, 0);
    add(0, 64'h0,    0, 0, 0, 0, 1,  3, 1, 2, 64'h102,  0, 0, 1);
    add(0, 64'h0,    0, 0, 0, 0, 1,  2, 1, 3, 64'h103,  0, 0, 1);
    add(0, 64'h0,    0, 0, 0, 0, 1,  1, 1, 4, 64'h104,  0, 0, 1);
    add(0, 64'h0,    0, 0, 0, 0, 1,  0, 0, 0, 64'h0,    0, 0, 1);
    add(1, 64'h107,  7, 0, 0, 0, 0,  1, 1, 7, 64'h107,  0, 0, 1);
    add(1, 64'h108,  8, 0, 0, 0, 1,  1, 1, 8, 64'h108,  0, 0, 1);
    add(0, 64'h0,    0, 0, 0, 0, 1,  0, 0, 0, 64'h0,    0, 0, 1);
    add(1, 64'hdead, 31, 0, 0, 0, 0, 0, 0, 0, 64'h0,    0, 0, 1);
    add(1, 64'habc,  31, 1, 1, 0, 0, 1, 1, 31, 64'habc, 1, 1, 1);
    add(0, 64'h0,    0, 0, 0, 0, 1,  0, 0, 0, 64'h0,    0, 0, 1);
    add(1, 64'h10a,  10, 0, 0, 0, 0, 1, 1, 10, 64'h10a, 0, 0, 1);
    add(1, 64'h10b,  11, 0, 0, 0, 0, 2, 1, 10, 64'h10a, 0, 0, 1);
    add(1, 64'h10c,  12, 0, 0, 0, 0, 3, 1, 10, 64'h10a, 0, 0, 1);
    add(1, 64'h109,  9, 0, 0, 1, 0,  0, 0, 0, 64'h0,    0, 0, 1);
    add(0, 64'h0,    0, 0, 0, 0, 1,  0, 0, 0, 64'h0,    0, 0, 1);

    drive(0, 64'h0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #12;
    chk("rst_count", 0, 64'(count), 64'd0);
    chk("rst_valid", 0, 64'(bus.cdb_valid), 64'd0);
    chk("rst_result", 0, bus.cdb_result, 64'd0);
    chk("rst_tag", 0, 64'(bus.cdb_tag), 64'd0);
    reset = 1'b1;
    #1;
    chk("rst_ready", 0, 64'(bus.X_ready), 64'd1);

    foreach (vecs[i]) begin
      @(negedge clock);
      drive(vecs[i].xv, vecs[i].res, vecs[i].tag, vecs[i].br, vecs[i].tk, vecs[i].fl,
            vecs[i].gr);
      @(posedge clock);
      #1;
      chk("v_count", i, 64'(count), 64'(vecs[i].e_cnt));
      chk("v_valid", i, 64'(bus.cdb_valid), 64'(vecs[i].e_valid));
      chk("v_tag", i, 64'(bus.cdb_tag), 64'(vecs[i].e_tag));
      chk("v_result", i, bus.cdb_result, vecs[i].e_res);
      chk("v_is_branch", i, 64'(bus.cdb_is_branch), 64'(vecs[i].e_br));
      chk("v_take_branch", i, 64'(bus.cdb_take_branch), 64'(vecs[i].e_tk));
      chk("v_ready", i, 64'(bus.X_ready), 64'(vecs[i].e_ready));
    end

    // No same-cycle bypass: push is invisible until after its edge.
    @(negedge clock);
    drive(1, 64'h55, 13, 0, 0, 0, 0);
    #1;
    chk("lat_pre_valid", 0, 64'(bus.cdb_valid), 64'd0);
    @(posedge clock);
    #1;
    chk("lat_post_valid", 0, 64'(bus.cdb_valid), 64'd1);
    chk("lat_post_tag", 0, 64'(bus.cdb_tag), 64'd13);
    @(negedge clock);
    drive(0, 64'h0, 0, 0, 0, 0, 1);
    @(posedge clock);
    #1;
    chk("lat_drain_count", 0, 64'(count), 64'd0);

    // Asynchronous reset with two entries buffered.
    @(negedge clock);
    drive(1, 64'h14, 14, 0, 0, 0, 0);
    @(negedge clock);
    drive(1, 64'h15, 15, 0, 0, 0, 0);
    @(negedge clock);
    drive(0, 64'h0, 0, 0, 0, 0, 0);
    chk("ar_pre_count", 0, 64'(count), 64'd2);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_count", 0, 64'(count), 64'd0);
    chk("ar_valid", 0, 64'(bus.cdb_valid), 64'd0);
    chk("ar_tag", 0, 64'(bus.cdb_tag), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    drive(1, 64'h77, 16, 0, 0, 0, 0);
    @(posedge clock);
    #1;
    chk("ar_push_count", 0, 64'(count), 64'd1);
    chk("ar_push_tag", 0, 64'(bus.cdb_tag), 64'd16);
    chk("ar_push_result", 0, bus.cdb_result, 64'h77);
    @(negedge clock);
    drive(0, 64'h0, 0, 0, 0, 0, 1);
    @(posedge clock);
    #1;
    chk("ar_drain_count", 0, 64'(count), 64'd0);
    chk("ar_drain_valid", 0, 64'(bus.cdb_valid), 64'd0);

    @(negedge clock);
    drive(0, 64'h0, 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
